// File: rtl/cdb_pkg.sv
// cdb_pkg: shared definitions for the Common Data Bus arbiter.
//   TAG_W, DATA_W : default RoB tag and result widths
//   cdb_bcast_t   : one CDB broadcast {control, tag, result}
//   FU_*          : requester index of each functional unit
//   cdb_ptr_w()   : width of an index into N requesters (at least 1)
package cdb_pkg;

   localparam int unsigned TAG_W  = 7;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned N_FU   = 4;

   localparam int unsigned FU_RTYPE  = 0;
   localparam int unsigned FU_ITYPE  = 1;
   localparam int unsigned FU_LOAD   = 2;
   localparam int unsigned FU_BRANCH = 3;

   typedef struct packed {
      logic              control;
      logic [TAG_W-1:0]  tag;
      logic [DATA_W-1:0] result;
   } cdb_bcast_t;

   function automatic int unsigned cdb_ptr_w(input int unsigned n);
      return (n > 32'd1) ? unsigned'($clog2(n)) : 32'd1;
   endfunction

endpackage

// File: rtl/cdb_pick.sv
// cdb_pick: combinational circular priority picker.
//   req   : request vector, one bit per unit
//   start : index where the search begins; the search wraps modulo N_REQ
//   grant : one-hot (or zero) grant to the first set request at or after start
module cdb_pick import cdb_pkg::*; #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned PTR_W = cdb_ptr_w(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [PTR_W-1:0] start,
   output logic [N_REQ-1:0] grant
);

   logic             found;
   logic [PTR_W-1:0] idx;

   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = '0;
      for (int unsigned off = 0; off < N_REQ; off++) begin
         idx = PTR_W'((32'(start) + off) % N_REQ);
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: grants at most one completing functional unit per cycle onto the Common Data Bus
// and registers the winner's tag/result as the broadcast seen by reservation stations and RoB.
// Build option: define CDB_RR_EN for round-robin arbitration; otherwise fixed priority
// (lowest index wins, no pointer register).
//   clock, reset_n : rising-edge clock, asynchronous active-low reset
//   flush          : cancel this cycle's grant (broadcast already on the bus still completes)
//   req_valid      : unit i holds a completed result
//   req_tag        : unit i tag in [i*TAG_W +: TAG_W]
//   req_result     : unit i result in [i*DATA_W +: DATA_W]
//   req_ready      : combinational one-hot-or-zero grant
//   cdb_control    : registered broadcast valid
//   cdb_dest_tag   : registered broadcast tag (stale when cdb_control=0)
//   cdb_result     : registered broadcast value (stale when cdb_control=0)
module cdb_arbiter #(
   parameter int unsigned N_REQ  = cdb_pkg::N_FU,
   parameter int unsigned TAG_W  = cdb_pkg::TAG_W,
   parameter int unsigned DATA_W = cdb_pkg::DATA_W
) (
   input  logic                      clock,
   input  logic                      reset_n,
   input  logic                      flush,
   input  logic [N_REQ-1:0]          req_valid,
   input  logic [N_REQ*TAG_W-1:0]    req_tag,
   input  logic [N_REQ*DATA_W-1:0]   req_result,
   output logic [N_REQ-1:0]          req_ready,
   output logic                      cdb_control,
   output logic [TAG_W-1:0]          cdb_dest_tag,
   output logic [DATA_W-1:0]         cdb_result
);

   import cdb_pkg::*;

   localparam int unsigned PTR_W = cdb_ptr_w(N_REQ);

   logic [N_REQ-1:0]  grant;
   logic [PTR_W-1:0]  start;
   logic              granted;
   logic [TAG_W-1:0]  sel_tag;
   logic [DATA_W-1:0] sel_result;
   logic              control_q;
   logic [TAG_W-1:0]  tag_q;
   logic [DATA_W-1:0] result_q;

`ifdef CDB_RR_EN
   logic [PTR_W-1:0] ptr_q, ptr_d;
   logic [PTR_W-1:0] gidx;

   assign start = ptr_q;
`else
   assign start = '0;
`endif

   cdb_pick #(
      .N_REQ (N_REQ),
      .PTR_W (PTR_W)
   ) u_pick (
      .req   (req_valid),
      .start (start),
      .grant (grant)
   );

   // Gated by reset_n so no unit believes it handed off a result while the bus is held in reset.
   assign req_ready = (reset_n && !flush) ? grant : '0;
   assign granted   = |req_ready;

   // One-hot OR mux of the winning unit's tag and result.
   always_comb begin
      sel_tag    = '0;
      sel_result = '0;
`ifdef CDB_RR_EN
      gidx       = '0;
`endif
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (req_ready[i]) begin
            sel_tag    = sel_tag    | req_tag[i*TAG_W +: TAG_W];
            sel_result = sel_result | req_result[i*DATA_W +: DATA_W];
`ifdef CDB_RR_EN
            gidx       = PTR_W'(i);
`endif
         end
      end
   end

`ifdef CDB_RR_EN
   // Pointer advances past the winner; flush and idle cycles leave it alone (granted is 0).
   always_comb begin
      ptr_d = ptr_q;
      if (granted) begin
         if (gidx == PTR_W'(N_REQ - 1)) begin
            ptr_d = '0;
         end else begin
            ptr_d = gidx + PTR_W'(1);
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end
`endif

   // Tag/result only load on a grant; consumers ignore them while control is low.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         control_q <= 1'b0;
         tag_q     <= '0;
         result_q  <= '0;
      end else begin
         control_q <= granted;
         if (granted) begin
            tag_q    <= sel_tag;
            result_q <= sel_result;
         end
      end
   end

   assign cdb_control  = control_q;
   assign cdb_dest_tag = tag_q;
   assign cdb_result   = result_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed bench for cdb_arbiter; expectations follow the build's arbitration mode.
module tb_cdb_arbiter;

`ifdef CDB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic        clock;
   logic        reset_n;
   logic        flush;
   logic [3:0]  req_valid;
   logic [27:0] req_tag;
   logic [127:0] req_result;
   logic [3:0]  req_ready;
   logic        cdb_control;
   logic [6:0]  cdb_dest_tag;
   logic [31:0] cdb_result;

   int n_cmp = 0;
   int n_err = 0;

   cdb_arbiter u_dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .flush        (flush),
      .req_valid    (req_valid),
      .req_tag      (req_tag),
      .req_result   (req_result),
      .req_ready    (req_ready),
      .cdb_control  (cdb_control),
      .cdb_dest_tag (cdb_dest_tag),
      .cdb_result   (cdb_result)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   task automatic set_unit(input int i, input logic [6:0] t, input logic [31:0] r);
      req_tag[i*7 +: 7]     = t;
      req_result[i*32 +: 32] = r;
   endtask

   // Drive one cycle at the negedge, check the combinational grant, then step past the posedge.
   task automatic cycle(input string tag, input logic [3:0] v, input logic fl,
                        input logic [3:0] exp_ready);
      @(negedge clock);
      req_valid = v;
      flush     = fl;
      #1;
      check_eq({tag, "_ready"}, 32'(req_ready), 32'(exp_ready));
      @(posedge clock);
      #1;
   endtask

   task automatic check_bus(input string tag, input logic ctl, input logic [6:0] t,
                            input logic [31:0] r);
      check_eq({tag, "_ctl"}, 32'(cdb_control), 32'(ctl));
      check_eq({tag, "_tag"}, 32'(cdb_dest_tag), 32'(t));
      check_eq({tag, "_res"}, cdb_result, r);
   endtask

   initial begin
      reset_n    = 1'b0;
      flush      = 1'b0;
      req_valid  = 4'b1111;
      req_tag    = '0;
      req_result = '0;
      set_unit(0, 7'h05, 32'hDEADBEEF);
      for (int i = 1; i < 4; i++) set_unit(i, 7'(10 + i), 32'hA000_0000 + 32'(i));

      // Reset: bus cleared, no grant even with requests pending.
      #3;
      check_eq("rst_ready", 32'(req_ready), 32'h0);
      check_bus("rst", 1'b0, 7'h00, 32'h0);

      @(negedge clock);
      reset_n   = 1'b1;
      req_valid = 4'b0000;
      #1;
      check_eq("rel_ready", 32'(req_ready), 32'h0);
      @(posedge clock);
      #1;
      check_eq("rel_ctl", 32'(cdb_control), 32'h0);

      // Single request, one-cycle latency.
      cycle("single", 4'b0001, 1'b0, 4'b0001);
      check_bus("single", 1'b1, 7'h05, 32'hDEADBEEF);
      cycle("idle", 4'b0000, 1'b0, 4'b0000);
      check_bus("idle", 1'b0, 7'h05, 32'hDEADBEEF);

      // Fresh reset so the pointer starts at 0 for the all-valid run.
      @(negedge clock);
      reset_n = 1'b0;
      #1;
      reset_n = 1'b1;
      set_unit(0, 7'd10, 32'hA000_0000);

      for (int c = 0; c < 4; c++) begin
         cycle($sformatf("all%0d", c), 4'b1111, 1'b0, RR ? 4'(1 << c) : 4'b0001);
         check_bus($sformatf("all%0d", c), 1'b1, RR ? 7'(10 + c) : 7'd10,
                   RR ? 32'hA000_0000 + 32'(c) : 32'hA000_0000);
      end

      // Wrap-around: grant 2 moves ptr to 3; then 1001 -> 3, then 0; then 0011 shows ptr=1.
      cycle("w2", 4'b0100, 1'b0, 4'b0100);
      check_bus("w2", 1'b1, 7'd12, 32'hA000_0002);
      cycle("w3", 4'b1001, 1'b0, RR ? 4'b1000 : 4'b0001);
      check_bus("w3", 1'b1, RR ? 7'd13 : 7'd10, RR ? 32'hA000_0003 : 32'hA000_0000);
      cycle("w0", 4'b1001, 1'b0, 4'b0001);
      check_bus("w0", 1'b1, 7'd10, 32'hA000_0000);
      cycle("wp", 4'b0011, 1'b0, RR ? 4'b0010 : 4'b0001);
      check_bus("wp", 1'b1, RR ? 7'd11 : 7'd10, RR ? 32'hA000_0001 : 32'hA000_0000);

      // Flush: broadcast already on the bus is kept, new grant suppressed, ptr frozen at 2.
      cycle("flush", 4'b0110, 1'b1, 4'b0000);
      check_eq("flush_ctl", 32'(cdb_control), 32'h0);
      cycle("postfl", 4'b0110, 1'b0, RR ? 4'b0100 : 4'b0010);
      check_bus("postfl", 1'b1, RR ? 7'd12 : 7'd11, RR ? 32'hA000_0002 : 32'hA000_0001);

      // Asynchronous reset mid-broadcast clears the bus before the next edge.
      #2;
      reset_n = 1'b0;
      #1;
      check_bus("arst", 1'b0, 7'h00, 32'h0);
      check_eq("arst_ready", 32'(req_ready), 32'h0);
      #4;
      reset_n = 1'b1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
